dbg_event_writer: RTL and testbench
===================================

// Module: dbg_event_writer
// PURPOSE
//  Initiator side of the PE debug write port. Hardware sources (DMNI, scheduler, safety monitor) post typed
//  debug events over valid/ready; the block buffers them and issues en/we/addr/data write beats to the
//  simulation debug sink, sharing that port with the CPU through an arbiter grant. SAFE events expand to 4 beats.
// PARAMETERS
//  FIFO_DEPTH  4  event FIFO entries; power of 2, >=2
// PORTS
//  clk_i        in   1    clock
//  rst_ni       in   1    reset; synchronous, active-low
//  evt_valid_i  in   1    event offered
//  evt_ready_o  out  1    event accepted when valid&&ready at posedge
//  evt_kind_i   in   4    dbg_evt_kind_t
//  evt_data_i   in   128  payload; w0=[31:0] .. w3=[127:96]
//  gnt_i        in   1    arbiter grant; beat completes on posedge with en_o&&gnt_i
//  en_o         out  1    debug port enable
//  we_o         out  1    write enable; always equal to en_o
//  addr_o       out  24   debug address
//  data_o       out  32   write data
//  halted_o     out  1    HALT beat issued; block frozen
//  err_o        out  1    1-cycle pulse: invalid kind popped (or drop, see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE; evt_ready_o=1 from first cycle after rst_ni high.
//  Reset mid-beat abandons the beat and flushes the FIFO; no partial SAFE continuation afterwards.
//  evt_ready_o = !full && !halted; no full-with-pop passthrough.
//  Kind->beats (addr,data): UART 000000,{24'h0,w0[7:0]}; HALT 000004,w0; TRAFFIC 000008,{16'h0,w0[15:0]};
//   SCHED 000010,w0; PIPE_ADD/REM 000020/24; REQ_ADD/REM 000030/34; AV_ADD/REM 000040/44 (data w0);
//   SAFE 4 beats: 000050 w0 (timestamp), 000054 w1 (latency), 000058 w2 (edge), 00005C w3; order fixed.
//  FSM IDLE: FIFO non-empty -> pop head into event reg, go SEND beat 0. Invalid kind: pop, pulse err_o, stay IDLE.
//  SEND: en_o=we_o=1, addr_o/data_o registered and held stable until gnt_i. On grant: non-last beat -> beat+1;
//   last beat: HALT -> HALTED; else FIFO non-empty -> load next, stay SEND (back-to-back, no bubble); else IDLE.
//  HALTED: en_o=0, halted_o=1, evt_ready_o=0, FIFO contents retained but never issued; exit only via reset.
//  Latency: event accepted into empty FIFO at edge N -> en_o high in cycle N+2 (load at N+1 edge).
//  en_o drops to 0 and addr_o/data_o hold last values when not in SEND.
//  Beat counter 2 bits; FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differ, rest equal.
// CONFIGURATION
//  DBG_EVENT_WRITER_DROP_EN defined: evt_ready_o=1 always (except HALTED); event offered while full is dropped,
//   err_o pulses, 16-bit saturating drop counter increments; on next IDLE with drops>0 a TRAFFIC-independent
//   beat addr 000060 data {16'h0,drops} is issued before the next event and counter clears on its grant.
//  Undefined: backpressure only, no counter, no 000060 beat.
// STRUCTURE
//  Package DbgWriterPkg: dbg_evt_kind_t enum (UART=0,HALT,TRAFFIC,SCHED,PIPE_ADD,PIPE_REM,REQ_ADD,REQ_REM,
//   AV_ADD,AV_REM,SAFE; 11-15 invalid), DBG_ADDR_* 24-bit constants, dbg_evt_t packed struct {kind,data}.
//  Sub-module dbg_evt_fifo: synchronous FIFO of dbg_evt_t, FIFO_DEPTH param, push/pop/full/empty.
//  FSM, beat sequencer and optional drop counter live in top.
// TESTING
//  Single UART 'A' with gnt_i=1 -> one beat addr 000000 data 00000041 in cycle N+2; en_o low next cycle.
//  SAFE w0..w3=10,20,0x00030004,7 with gnt_i low 3 cycles per beat -> beats 50/54/58/5C data 10,20,30004,7, held stable.
//  5 SCHED events, gnt_i=0, depth 4 -> evt_ready_o low after 4 in FIFO+reg; release gnt_i -> 5 beats in order, no bubbles.
//  HALT then PIPE_ADD -> beat 000004, halted_o=1, PIPE beat never appears, evt_ready_o=0 until reset.
//  Kind 14 -> no beat, err_o 1-cycle pulse; rst_ni low mid-SAFE beat 1 -> en_o 0 next cycle, FIFO empty.
//  DROP_EN: 7 events with gnt_i=0 -> 2 drops; on grant 5 beats, then addr 000060 data 2 before next event.

Source files
------------

// File: rtl/dbg_event_writer_pkg.sv
// Shared types for the PE debug event writer.
// Event kinds, debug sink addresses and beat helpers.
package DbgWriterPkg;

   typedef enum logic [3:0] {
      EVT_UART     = 4'd0,
      EVT_HALT     = 4'd1,
      EVT_TRAFFIC  = 4'd2,
      EVT_SCHED    = 4'd3,
      EVT_PIPE_ADD = 4'd4,
      EVT_PIPE_REM = 4'd5,
      EVT_REQ_ADD  = 4'd6,
      EVT_REQ_REM  = 4'd7,
      EVT_AV_ADD   = 4'd8,
      EVT_AV_REM   = 4'd9,
      EVT_SAFE     = 4'd10
   } dbg_evt_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_HALTED = 2'd2
   } dbg_state_t;

   localparam logic [23:0] DBG_ADDR_UART     = 24'h000000;
   localparam logic [23:0] DBG_ADDR_HALT     = 24'h000004;
   localparam logic [23:0] DBG_ADDR_TRAFFIC  = 24'h000008;
   localparam logic [23:0] DBG_ADDR_SCHED    = 24'h000010;
   localparam logic [23:0] DBG_ADDR_PIPE_ADD = 24'h000020;
   localparam logic [23:0] DBG_ADDR_PIPE_REM = 24'h000024;
   localparam logic [23:0] DBG_ADDR_REQ_ADD  = 24'h000030;
   localparam logic [23:0] DBG_ADDR_REQ_REM  = 24'h000034;
   localparam logic [23:0] DBG_ADDR_AV_ADD   = 24'h000040;
   localparam logic [23:0] DBG_ADDR_AV_REM   = 24'h000044;
   localparam logic [23:0] DBG_ADDR_SAFE     = 24'h000050;
   localparam logic [23:0] DBG_ADDR_DROP     = 24'h000060;

   // Kind is kept raw so codes 11-15 survive the FIFO and can be flagged.
   typedef struct packed {
      logic [3:0]   kind;
      logic [127:0] data;
   } dbg_evt_t;

   function automatic logic kind_ok(input logic [3:0] k);
      return k <= EVT_SAFE;
   endfunction

   function automatic logic [1:0] last_beat(input logic [3:0] k);
      return (k == EVT_SAFE) ? 2'd3 : 2'd0;
   endfunction

   function automatic logic [23:0] beat_addr(input logic [3:0] k,
                                             input logic [1:0] b);
      logic [23:0] a;
      a = DBG_ADDR_UART;
      case (k)
         EVT_HALT:     a = DBG_ADDR_HALT;
         EVT_TRAFFIC:  a = DBG_ADDR_TRAFFIC;
         EVT_SCHED:    a = DBG_ADDR_SCHED;
         EVT_PIPE_ADD: a = DBG_ADDR_PIPE_ADD;
         EVT_PIPE_REM: a = DBG_ADDR_PIPE_REM;
         EVT_REQ_ADD:  a = DBG_ADDR_REQ_ADD;
         EVT_REQ_REM:  a = DBG_ADDR_REQ_REM;
         EVT_AV_ADD:   a = DBG_ADDR_AV_ADD;
         EVT_AV_REM:   a = DBG_ADDR_AV_REM;
         EVT_SAFE:     a = DBG_ADDR_SAFE + {20'h0, b, 2'b00};
         default:      a = DBG_ADDR_UART;
      endcase
      return a;
   endfunction

   function automatic logic [31:0] beat_data(input logic [3:0]   k,
                                             input logic [1:0]   b,
                                             input logic [127:0] d);
      logic [31:0] w;
      w = d[31:0];
      case (k)
         EVT_UART:    w = {24'h0, d[7:0]};
         EVT_TRAFFIC: w = {16'h0, d[15:0]};
         EVT_SAFE:    w = d[{b, 5'b0} +: 32];
         default:     w = d[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dbg_event_writer_fifo.sv
// Event FIFO for the debug writer.
// Pointers carry one extra wrap bit to split full from empty.
module dbg_evt_fifo
   import DbgWriterPkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  dbg_evt_t din_i,
   input  logic     pop_i,
   output dbg_evt_t dout_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   dbg_evt_t    mem [FIFO_DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem[rd_q[AW-1:0]];

   // Pointer update; reset flushes the queue
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

   // Storage write
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/dbg_event_writer.sv
// Debug event writer: buffers typed events, issues debug port beats.
// Optional DBG_EVENT_WRITER_DROP_EN: drop-on-full with counter beat.
module dbg_event_writer
   import DbgWriterPkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         evt_valid_i,
   output logic         evt_ready_o,
   input  logic [3:0]   evt_kind_i,
   input  logic [127:0] evt_data_i,
   input  logic         gnt_i,
   output logic         en_o,
   output logic         we_o,
   output logic [23:0]  addr_o,
   output logic [31:0]  data_o,
   output logic         halted_o,
   output logic         err_o
);

   dbg_state_t  state_q, state_d;
   dbg_evt_t    evt_in, head, evt_q;
   logic        full, empty, push, pop, ready;
   logic        load, step, load_drop, bad;
   logic [1:0]  beat_q, beat_nx;
   logic        drop_beat_q, run_q, err_q, last;
   logic        drop_now, drops_pend;
   logic [15:0] drop_word;
   logic [23:0] addr_q;
   logic [31:0] data_q;

   assign evt_in.kind = evt_kind_i;
   assign evt_in.data = evt_data_i;

`ifdef DBG_EVENT_WRITER_DROP_EN
   logic [15:0] drops_q, drops_base;

   assign ready      = run_q && (state_q != ST_HALTED);
   assign drop_now   = evt_valid_i && ready && full;
   assign drops_pend = (drops_q != 16'h0);
   assign drop_word  = drops_q;
   assign drops_base = (state_q == ST_SEND && gnt_i && drop_beat_q) ?
                       drops_q - data_q[15:0] : drops_q;

   // Saturating drop count; a granted drop beat retires what it reported
   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         drops_q <= '0;
      else if (drop_now && drops_base != 16'hFFFF)
         drops_q <= drops_base + 16'd1;
      else
         drops_q <= drops_base;
   end
`else
   assign ready      = run_q && (state_q != ST_HALTED) && !full;
   assign drop_now   = 1'b0;
   assign drops_pend = 1'b0;
   assign drop_word  = 16'h0;
`endif

   assign push    = evt_valid_i && ready && !full;
   assign last    = drop_beat_q || (beat_q == last_beat(evt_q.kind));
   assign beat_nx = beat_q + 2'd1;

   dbg_evt_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push),
      .din_i  (evt_in),
      .pop_i  (pop),
      .dout_o (head),
      .full_o (full),
      .empty_o(empty)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state and sequencing strobes
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      load_drop = 1'b0;
      bad       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drops_pend) begin
               load_drop = 1'b1;
               state_d   = ST_SEND;
            end else if (!empty) begin
               pop = 1'b1;
               if (kind_ok(head.kind)) begin
                  load    = 1'b1;
                  state_d = ST_SEND;
               end else begin
                  bad = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (gnt_i) begin
               if (!last) begin
                  step = 1'b1;
               end else if (!drop_beat_q && evt_q.kind == EVT_HALT) begin
                  state_d = ST_HALTED;
               end else if (!empty && kind_ok(head.kind)) begin
                  pop  = 1'b1;
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Event register, beat counter and registered port values
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         evt_q       <= '0;
         beat_q      <= '0;
         drop_beat_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         run_q <= 1'b1;
         err_q <= bad || drop_now;
         if (load) begin
            evt_q       <= head;
            beat_q      <= 2'd0;
            drop_beat_q <= 1'b0;
            addr_q      <= beat_addr(head.kind, 2'd0);
            data_q      <= beat_data(head.kind, 2'd0, head.data);
         end else if (load_drop) begin
            drop_beat_q <= 1'b1;
            addr_q      <= DBG_ADDR_DROP;
            data_q      <= {16'h0, drop_word};
         end else if (step) begin
            beat_q <= beat_nx;
            addr_q <= beat_addr(evt_q.kind, beat_nx);
            data_q <= beat_data(evt_q.kind, beat_nx, evt_q.data);
         end
      end
   end

   assign evt_ready_o = ready;
   assign en_o        = (state_q == ST_SEND);
   assign we_o        = (state_q == ST_SEND);
   assign addr_o      = addr_q;
   assign data_o      = data_q;
   assign halted_o    = (state_q == ST_HALTED);
   assign err_o       = err_q;

endmodule

// File: tb/tb_dbg_event_writer.sv
// Self-checking bench for dbg_event_writer.
// Scoreboard of expected beats plus directed literal checks.
module tb_dbg_event_writer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         evt_valid;
   logic         evt_ready;
   logic [3:0]   evt_kind;
   logic [127:0] evt_data;
   logic         gnt;
   logic         en, we, halted, err;
   logic [23:0]  addr;
   logic [31:0]  data;

   always #5 clk = ~clk;

   dbg_event_writer #(.FIFO_DEPTH(4)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .evt_valid_i(evt_valid),
      .evt_ready_o(evt_ready),
      .evt_kind_i (evt_kind),
      .evt_data_i (evt_data),
      .gnt_i      (gnt),
      .en_o       (en),
      .we_o       (we),
      .addr_o     (addr),
      .data_o     (data),
      .halted_o   (halted),
      .err_o      (err)
   );

   typedef struct {
      logic [23:0] a;
      logic [31:0] d;
   } beat_t;

   beat_t       exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          err_seen = 0;
   bit          chk_en = 0;
   bit          model_on = 1;
   bit          halted_m = 0;
   logic [23:0] addr_tab [0:9] = '{24'h00, 24'h04, 24'h08, 24'h10, 24'h20,
                                   24'h24, 24'h30, 24'h34, 24'h40, 24'h44};
   logic [127:0] safe_d = {32'd7, 32'h00030004, 32'd20, 32'd10};
   logic [23:0]  safe_a [0:3] = '{24'h50, 24'h54, 24'h58, 24'h5C};
   logic [31:0]  safe_w [0:3] = '{32'd10, 32'd20, 32'h00030004, 32'd7};

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // What the debug sink must see for one accepted event
   function automatic void model_push(input logic [3:0] k,
                                      input logic [127:0] d);
      logic [31:0] w;
      if (halted_m || k > 4'd10) return;
      if (k == 4'd10) begin
         for (int b = 0; b < 4; b++)
            exp_q.push_back('{24'h50 + 24'(4 * b), d[32 * b +: 32]});
      end else begin
         w = d[31:0];
         if (k == 4'd0) w = w % 256;
         if (k == 4'd2) w = w % 65536;
         exp_q.push_back('{addr_tab[k], w});
         if (k == 4'd1) halted_m = 1;
      end
   endfunction

   // Every enabled cycle must show the head expected beat
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         if (en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got beat %h/%h required none",
                        addr, data);
            end else begin
               chk("sb_addr", addr, exp_q[0].a);
               chk("sb_data", data, exp_q[0].d);
               chk("sb_we", we, 1);
               if (gnt) void'(exp_q.pop_front());
            end
         end else begin
            chk("sb_we_idle", we, 0);
         end
         if (err) err_seen++;
      end
   end

   task automatic do_reset();
      chk_en    = 0;
      rst_n     = 0;
      evt_valid = 0;
      gnt       = 0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      halted_m = 0;
      err_seen = 0;
      rst_n    = 1;
      @(posedge clk);
      #1;
      chk_en = 1;
   endtask

   task automatic send(input logic [3:0] k, input logic [127:0] d);
      bit ok;
      ok        = 0;
      evt_valid = 1;
      evt_kind  = k;
      evt_data  = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (evt_ready) begin
            @(posedge clk);
            #1;
            ok = 1;
         end
      end
      evt_valid = 0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: kind %0d got ready 0 required 1", k);
      end else if (model_on) begin
         model_push(k, d);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int en_cnt;
      rst_n     = 0;
      evt_valid = 0;
      evt_kind  = '0;
      evt_data  = '0;
      gnt       = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_en", en, 0);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", evt_ready, 0);
      do_reset();
      chk("ready_after_rst", evt_ready, 1);

      // single UART 'A', latency and one-beat width
      gnt = 1;
      send(4'd0, 128'h141);
      @(negedge clk);
      chk("uart_lat_en0", en, 0);
      @(negedge clk);
      chk("uart_en", en, 1);
      chk("uart_addr", addr, 24'h000000);
      chk("uart_data", data, 32'h00000041);
      @(negedge clk);
      chk("uart_en_drop", en, 0);
      chk("uart_model_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // SAFE with three stalled cycles per beat
      gnt = 0;
      send(4'd10, safe_d);
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("safe_en", en, 1);
            chk("safe_addr", addr, safe_a[b]);
            chk("safe_data", data, safe_w[b]);
            @(posedge clk);
            #1;
            gnt = (c == 2);
         end
      end
      @(negedge clk);
      chk("safe_done_en", en, 0);
      @(posedge clk);
      #1;

`ifndef DBG_EVENT_WRITER_DROP_EN
      // backpressure: 4 in FIFO + 1 in the event register
      do_reset();
      for (int i = 0; i < 6; i++) begin
         evt_valid = 1;
         evt_kind  = 4'd3;
         evt_data  = 128'(i + 1);
         @(negedge clk);
         chk("bp_ready", evt_ready, (i < 5));
         if (evt_ready) model_push(4'd3, 128'(i + 1));
         @(posedge clk);
         #1;
      end
      evt_valid = 0;
      gnt = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_en", en, 1);
         chk("bp_addr", addr, 24'h000010);
         chk("bp_data", data, 32'(i + 1));
      end
      @(negedge clk);
      chk("bp_end_en", en, 0);
      @(posedge clk);
      #1;
`else
      // drop mode: 2 of 7 dropped, count beat after the drain
      do_reset();
      model_on = 0;
      for (int i = 0; i < 7; i++) begin
         evt_valid = 1;
         evt_kind  = 4'd3;
         evt_data  = 128'(i + 1);
         @(negedge clk);
         chk("drop_ready", evt_ready, 1);
         @(posedge clk);
         #1;
      end
      evt_valid = 0;
      for (int i = 0; i < 5; i++) exp_q.push_back('{24'h10, 32'(i + 1)});
      exp_q.push_back('{24'h60, 32'd2});
      gnt = 1;
      drain();
      chk("drop_err", err_seen, 2);
      model_on = 1;
      send(4'd0, 128'h5A);
      drain();
`endif

      // HALT freezes the block, later event never issued
      do_reset();
      gnt = 1;
      send(4'd1, 128'hDEADBEEF);
      send(4'd4, 128'h5);
      repeat (8) @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_ready", evt_ready, 0);
      chk("halt_en", en, 0);
      chk("halt_model_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
      evt_valid = 1;
      evt_kind  = 4'd0;
      @(negedge clk);
      chk("halt_ready_offer", evt_ready, 0);
      @(posedge clk);
      #1;
      evt_valid = 0;

      // invalid kind: no beat, one-cycle error
      do_reset();
      gnt = 1;
      send(4'd14, 128'h0);
      repeat (4) @(negedge clk);
      chk("bad_err_pulse", err_seen, 1);
      chk("bad_halted", halted, 0);
      @(posedge clk);
      #1;
      send(4'd2, 128'h12345678);
      drain();

      // reset during SAFE beat 1 abandons it and flushes the FIFO
      do_reset();
      send(4'd10, safe_d);
      send(4'd0, 128'h43);
      gnt = 1;
      @(posedge clk);
      #1;
      gnt = 0;
      @(negedge clk);
      chk("mid_addr", addr, 24'h000054);
      chk_en = 0;
      rst_n  = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_en", en, 0);
      chk("mid_rst_addr", addr, 0);
      exp_q.delete();
      halted_m = 0;
      rst_n    = 1;
      @(posedge clk);
      #1;
      chk_en = 1;
      gnt    = 1;
      en_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (en) en_cnt++;
      end
      chk("mid_no_beats", en_cnt, 0);
      chk("mid_ready", evt_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
